// File: rtl/demux_router_1to4.sv
// Registered 1-to-4 demultiplexer: each word is routed to the lane chosen by {address1, address0}.
// Each lane has a one-entry buffer. Define DEMUX_ROUTER_STALL_COUNT_EN to add the stall_count port.
module demux_router_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             address0,
    input  logic             address1,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic             out_valid3,
    input  logic             out_ready0,
    input  logic             out_ready1,
    input  logic             out_ready2,
    input  logic             out_ready3,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3
`ifdef DEMUX_ROUTER_STALL_COUNT_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } laneState_t;

    laneState_t       laneState [4];
    laneState_t       laneNext  [4];
    logic [WIDTH-1:0] laneData  [4];
    logic [1:0]       sel;
    logic [3:0]       outReady;
    logic [3:0]       load;
    logic             accept;

    assign sel      = {address1, address0};
    assign outReady = {out_ready3, out_ready2, out_ready1, out_ready0};

    // A full lane can still take a word when its consumer is draining it in the same cycle.
    assign in_ready = (laneState[sel] == EMPTY) || outReady[sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        load     = '0;
        laneNext = laneState;
        for (int n = 0; n < 4; n++) begin
            if (accept && (sel == 2'(n))) begin
                load[n]     = 1'b1;
                laneNext[n] = FULL;
            end else if ((laneState[n] == FULL) && outReady[n]) begin
                laneNext[n] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                laneState[n] <= EMPTY;
                laneData[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                laneState[n] <= laneNext[n];
                if (load[n]) begin
                    laneData[n] <= in_data;
                end
            end
        end
    end

    assign out_valid0 = (laneState[0] == FULL);
    assign out_valid1 = (laneState[1] == FULL);
    assign out_valid2 = (laneState[2] == FULL);
    assign out_valid3 = (laneState[3] == FULL);
    assign out_data0  = laneData[0];
    assign out_data1  = laneData[1];
    assign out_data2  = laneData[2];
    assign out_data3  = laneData[3];

`ifdef DEMUX_ROUTER_STALL_COUNT_EN
    // Counts cycles the producer is blocked; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_router_1to4.sv
// Self-checking bench for demux_router_1to4: directed scenarios followed by random traffic,
// compared against a per-lane one-slot buffer model.
module tb_demux_router_1to4;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             address0;
    logic             address1;
    logic             out_valid0, out_valid1, out_valid2, out_valid3;
    logic             out_ready0, out_ready1, out_ready2, out_ready3;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_ROUTER_STALL_COUNT_EN
    logic [15:0]      stall_count;
`endif

    demux_router_1to4 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .address0   (address0),
        .address1   (address1),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_valid3 (out_valid3),
        .out_ready0 (out_ready0),
        .out_ready1 (out_ready1),
        .out_ready2 (out_ready2),
        .out_ready3 (out_ready3),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3)
`ifdef DEMUX_ROUTER_STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference: each lane is a one-word mailbox that is either occupied or not.
    int               numChecks = 0;
    int               numFails  = 0;
    bit               mFull [4];
    logic [WIDTH-1:0] mData [4];
    int               mStall;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        assert (observed === expected)
        else begin
            numFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " valid0"}, {31'd0, out_valid0}, {31'd0, mFull[0]});
        checkValue({tag, " valid1"}, {31'd0, out_valid1}, {31'd0, mFull[1]});
        checkValue({tag, " valid2"}, {31'd0, out_valid2}, {31'd0, mFull[2]});
        checkValue({tag, " valid3"}, {31'd0, out_valid3}, {31'd0, mFull[3]});
        checkValue({tag, " data0"}, {24'd0, out_data0}, {24'd0, mData[0]});
        checkValue({tag, " data1"}, {24'd0, out_data1}, {24'd0, mData[1]});
        checkValue({tag, " data2"}, {24'd0, out_data2}, {24'd0, mData[2]});
        checkValue({tag, " data3"}, {24'd0, out_data3}, {24'd0, mData[3]});
`ifdef DEMUX_ROUTER_STALL_COUNT_EN
        checkValue({tag, " stall"}, {16'd0, stall_count}, 32'(mStall));
`endif
    endtask

    // One clock: drive inputs, check in_ready before the edge, advance the model, check after.
    task automatic applyStimulus(input string tag, input bit valid, input int addr,
                                 input logic [WIDTH-1:0] data, input logic [3:0] ready);
        bit expReady;
        in_valid = valid;
        {address1, address0} = 2'(addr);
        in_data = data;
        {out_ready3, out_ready2, out_ready1, out_ready0} = ready;
        #2;
        expReady = !mFull[addr] || ready[addr];
        checkValue({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, expReady});
        @(posedge clk);
        for (int n = 0; n < 4; n++) begin
            if (valid && expReady && n == addr) begin
                mFull[n] = 1'b1;
                mData[n] = data;
            end else if (mFull[n] && ready[n]) begin
                mFull[n] = 1'b0;
            end
        end
        if (valid && !expReady && mStall < 65535) mStall++;
        #1;
        checkOutput(tag);
    endtask

    task automatic applyReset(input string tag);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        {address1, address0} = 2'd0;
        {out_ready3, out_ready2, out_ready1, out_ready0} = 4'h0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            mFull[n] = 1'b0;
            mData[n] = '0;
        end
        mStall = 0;
        checkOutput(tag);
        for (int a = 0; a < 4; a++) begin
            {address1, address0} = 2'(a);
            #1;
            checkValue($sformatf("%s in_ready addr%0d", tag, a), {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        {address1, address0} = 2'd0;
        {out_ready3, out_ready2, out_ready1, out_ready0} = 4'h0;
        mStall = 0;
        @(posedge clk);
        #1;
        applyReset("reset");

        applyStimulus("route", 1'b1, 2, 8'hA5, 4'h0);
        applyStimulus("drain", 1'b0, 0, 8'h00, 4'hF);

        applyStimulus("bp load", 1'b1, 1, 8'h11, 4'h0);
        applyStimulus("bp blocked", 1'b1, 1, 8'h22, 4'h0);
        applyStimulus("bp release", 1'b1, 1, 8'h22, 4'b0010);
        applyStimulus("drain", 1'b0, 0, 8'h00, 4'hF);

        for (int i = 1; i <= 8; i++) begin
            applyStimulus($sformatf("stream%0d", i), 1'b1, 3, 8'(i), 4'b1000);
        end
        applyStimulus("drain", 1'b0, 0, 8'h00, 4'hF);

        applyStimulus("indep lane0", 1'b1, 0, 8'h55, 4'h0);
        applyStimulus("indep lane2", 1'b1, 2, 8'h3C, 4'h0);

        applyReset("reset2");
        applyStimulus("stall fill0", 1'b1, 0, 8'h10, 4'h0);
        applyStimulus("stall fill1", 1'b1, 1, 8'h20, 4'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("stall%0d", i), 1'b1, i % 2, 8'h77, 4'h0);
        end
`ifdef DEMUX_ROUTER_STALL_COUNT_EN
        checkValue("stall five", {16'd0, stall_count}, 32'd5);
`endif
        applyReset("reset mid");

        for (int i = 0; i < 400; i++) begin
            applyStimulus($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          8'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/demux_router_1to4.md
Name: demux_router_1to4

Overview:
- Registered 1-to-4 demultiplexer with a valid/ready handshake on every port.
- Routes each input word to the output lane selected by {address1, address0}.
- Each lane has a one-entry holding register, so the lanes drain independently.
- This is the distribution-side counterpart of the 4:1 selection logic. It feeds per-lane consumers from a single producer.

Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts the word this cycle (combinational).
- in_data  input  WIDTH  word to route.
- address0  input  1  lane select LSB, sampled with in_valid.
- address1  input  1  lane select MSB, sampled with in_valid.
- out_valid0..out_valid3  output  1 each  lane n holds a word.
- out_ready0..out_ready3  input  1 each  consumer n takes the word.
- out_data0..out_data3  output  WIDTH each  lane n held word.
- stall_count  output  16  saturating stall counter; present only with STALL_COUNT_EN.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Lane select: sel = {address1, address0}. 0 selects lane 0, 3 selects lane 3. address and in_data are don't-care while in_valid = 0.
- Per-lane state: a full flag, with states EMPTY and FULL.
- Output mapping: out_valid[n] = full[n]. out_data[n] is the lane register.
- Input ready: in_ready = !full[sel] | out_ready[sel]. It depends only on the selected lane and never on the other lanes.
- Accept: accept = in_valid & in_ready. On an accept, lane sel loads in_data and is FULL next cycle.
- Latency: a word accepted in cycle t appears on out_data[sel] with out_valid[sel] = 1 in cycle t+1.
- Drain: full[n] & out_ready[n] with no load into lane n makes lane n EMPTY next cycle.
- Simultaneous drain and load, same lane: the old word is consumed, the new word is loaded, and the lane stays FULL. Full throughput is one word per cycle into one lane.
- Simultaneous events, different lanes: fully independent. Any lanes may drain in the same cycle as a load into another lane.
- Hold: while out_valid[n] = 1 and out_ready[n] = 0, out_data[n] is stable and no lane register is overwritten.
- Blocked producer: in_valid = 1 and in_ready = 0 does not load. The producer may change the address while blocked; in_ready tracks the new sel combinationally.
- Reset values: all full = 0, all out_valid = 0, all out_data = 0, stall_count = 0.
- Reset mid-operation: buffered words are discarded and no handshake completes in the reset cycle. in_ready stays combinationally derived and reads 1, because all lanes are EMPTY after reset.
- Unknown address bits: not legal when in_valid = 1. The bench never drives them.

Optional Feature:
- Macro: DEMUX_ROUTER_STALL_COUNT_EN.
- With the macro defined:
  - The stall_count port exists.
  - It is a 16-bit counter that increments on every clock where in_valid = 1 and in_ready = 0.
  - It saturates at 16'hFFFF with no wrap, and clears on reset.
- Without the macro: the port and the counter logic are absent, and the other behaviour is identical.

Test Plan:
- Reset release: after reset, in_ready = 1 at addr 0..3 and all out_valid = 0.
- Single route: in_data = 8'hA5, addr 2, all out_ready = 0 -> cycle+1 out_valid2 = 1, out_data2 = 8'hA5, other lanes out_valid = 0.
- Backpressure: lane 1 FULL with 8'h11 and out_ready1 = 0, then present 8'h22 at addr 1 -> in_ready = 0, out_data1 holds 8'h11. Raising out_ready1 -> in_ready = 1, 8'h22 loads, out_data1 = 8'h22 next cycle.
- Streaming: out_ready3 = 1 held, 8'h01..8'h08 sent to addr 3 on consecutive cycles -> in_ready stays 1 and out_data3 shows 8'h01..8'h08 one cycle later, one per cycle.
- Independence: lane 0 FULL and stalled, word 8'h3C sent to addr 2 -> accepted, out_valid2 = 1 next cycle, lane 0 unchanged.
- Reset mid-flight plus counter (macro on): lanes 0 and 1 FULL, 5 blocked cycles -> stall_count = 5. Then reset -> all out_valid = 0, stall_count = 0.
